// File: rtl/hcsr04_pkg.sv
// Shared definitions for the HC-SR04 initiator/responder pair: FSM encoding,
// default tick constants and the echo-width selection rule.
package hcsr04_pkg;

   // Responder protocol phases.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TRIG,
      ST_BURST,
      ST_ECHO,
      ST_HOLDOFF
   } state_t;

   // 10 us tick at 50 MHz, and the longest echo the initiator accepts.
   localparam int unsigned HCSR04_CLK_PER_TICK = 500;
   localparam int unsigned HCSR04_MAX_TICKS    = 3800;

   // A request of 0 means "no object"; a request beyond the legal range is
   // reported the same way, so both collapse to the timeout width.
   function automatic logic [15:0] eff_ticks_f(input logic [15:0] req,
                                               input logic [15:0] max_t,
                                               input logic [15:0] timeout_t);
      if (req == 16'd0 || req > max_t) return timeout_t;
      return req;
   endfunction

endpackage

// File: rtl/hcsr04_tick_gen.sv
// Restartable prescaler: one-cycle tick every CLK_PER_TICK clocks. A restart
// realigns the phase so the first tick lands exactly CLK_PER_TICK cycles later.
module hcsr04_tick_gen #(
   parameter int unsigned CLK_PER_TICK = 500
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic tick
);

   localparam int unsigned CW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_PER_TICK - 1);

   logic [CW-1:0] cnt_q;

   assign tick = (cnt_q == LAST);

   // Prescaler count: wraps on the tick, clears on restart.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (restart || cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/hcsr04_responder.sv
// Sensor-side model of the HC-SR04 protocol: qualifies the trigger pulse,
// waits out the burst delay, then returns an echo whose width encodes the
// programmed distance, followed by the sensor re-arm holdoff.
module hcsr04_responder
   import hcsr04_pkg::*;
#(
   parameter int unsigned CLK_PER_TICK      = HCSR04_CLK_PER_TICK,
   parameter int unsigned MIN_TRIG_CYCLES   = 500,
   parameter int unsigned BURST_DELAY_TICKS = 45,
   parameter int unsigned MAX_TICKS         = HCSR04_MAX_TICKS,
   parameter int unsigned TIMEOUT_TICKS     = 3800,
   parameter int unsigned HOLDOFF_TICKS     = 6000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [15:0] echo_ticks,
   input  logic        trigger,
   output logic        echo,
   output logic        busy,
   output logic        ping_done,
   output logic        trig_err
);

   localparam logic [15:0] MIN_TRIG_W   = 16'(MIN_TRIG_CYCLES);
   localparam logic [15:0] BURST_LAST   = 16'(BURST_DELAY_TICKS - 1);
   localparam logic [15:0] HOLDOFF_LAST = 16'(HOLDOFF_TICKS - 1);
   localparam logic [15:0] MAX_W        = 16'(MAX_TICKS);
   localparam logic [15:0] TIMEOUT_W    = 16'(TIMEOUT_TICKS);

   state_t      state_q, state_d;
   logic        trig_meta_q, trig_s_q, trig_prev_q;
   logic [15:0] width_q;
   logic [15:0] tick_cnt_q;
   logic [15:0] eff_q;
   logic        echo_q, busy_q, ping_done_q, trig_err_q;
   logic        tick, restart;
   logic        trig_rise, trig_fall;

   assign trig_rise = trig_s_q & ~trig_prev_q;
   assign trig_fall = ~trig_s_q & trig_prev_q;
   assign restart   = (state_d != state_q);

   hcsr04_tick_gen #(
      .CLK_PER_TICK(CLK_PER_TICK)
   ) u_tick_gen (
      .clk    (clk),
      .rst_n  (rst_n),
      .restart(restart),
      .tick   (tick)
   );

   // Two-flop synchroniser for the asynchronous trigger plus edge-detect history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_meta_q <= 1'b0;
         trig_s_q    <= 1'b0;
         trig_prev_q <= 1'b0;
      end else begin
         trig_meta_q <= trigger;
         trig_s_q    <= trig_meta_q;
         trig_prev_q <= trig_s_q;
      end
   end

   // Next-state decision; tick-based exits compare with == on the last tick.
   // NOTE: state_d gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (trig_rise && enable) state_d = ST_TRIG;
         ST_TRIG:    if (trig_fall) state_d = (width_q >= MIN_TRIG_W) ? ST_BURST : ST_IDLE;
         ST_BURST:   if (tick && tick_cnt_q == BURST_LAST) state_d = ST_ECHO;
         ST_ECHO:    if (tick && tick_cnt_q == eff_q - 16'd1) state_d = ST_HOLDOFF;
         ST_HOLDOFF: if (tick && tick_cnt_q == HOLDOFF_LAST) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // FSM state, counters and registered outputs, all derived from the transition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         width_q     <= '0;
         tick_cnt_q  <= '0;
         eff_q       <= '0;
         echo_q      <= 1'b0;
         busy_q      <= 1'b0;
         ping_done_q <= 1'b0;
         trig_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         busy_q      <= (state_d != ST_IDLE);
         echo_q      <= (state_d == ST_ECHO);
         ping_done_q <= (state_q == ST_ECHO) && (state_d == ST_HOLDOFF);
         trig_err_q  <= (state_q == ST_TRIG) && (state_d == ST_IDLE);

         // Trigger width: cleared on acceptance of the rising edge, saturating.
         if (state_q == ST_IDLE && state_d == ST_TRIG) begin
            width_q <= '0;
         end else if (state_q == ST_TRIG && trig_s_q && width_q != 16'hFFFF) begin
            width_q <= width_q + 16'd1;
         end

         // Distance is frozen here; later echo_ticks changes wait for the next ping.
         if (state_q == ST_TRIG && state_d == ST_BURST) begin
            eff_q <= eff_ticks_f(echo_ticks, MAX_W, TIMEOUT_W);
         end

         // Tick counter runs only in the timed states and restarts with the prescaler.
         if (restart) begin
            tick_cnt_q <= '0;
         end else if (tick && (state_q == ST_BURST || state_q == ST_ECHO ||
                               state_q == ST_HOLDOFF)) begin
            tick_cnt_q <= tick_cnt_q + 16'd1;
         end
      end
   end

   assign echo      = echo_q;
   assign busy      = busy_q;
   assign ping_done = ping_done_q;
   assign trig_err  = trig_err_q;

endmodule

// File: tb/tb_hcsr04_responder.sv
// Directed bench for hcsr04_responder with shrunken tick constants so full
// pings (burst, echo, holdoff) fit in a few hundred cycles.
module tb_hcsr04_responder;

   localparam int CPT      = 4;
   localparam int MIN_TRIG = 8;
   localparam int BURST_T  = 3;
   localparam int MAX_T    = 20;
   localparam int TMO_T    = 15;
   localparam int HOLD_T   = 5;

   // Raw trigger fall -> echo rise: 3 sync/edge cycles plus the burst delay.
   localparam int EXP_RISE = 3 + BURST_T * CPT;
   localparam int EXP_HOLD = HOLD_T * CPT;
   localparam int BOUND    = 1000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        trigger = 1'b0;
   logic [15:0] echo_ticks = 16'd0;
   logic        echo, busy, ping_done, trig_err;

   int checks = 0;
   int errors = 0;

   int m_rise, m_width, m_hold, m_pd, m_te, m_pd_at_fall;

   always #5 clk = ~clk;

   hcsr04_responder #(
      .CLK_PER_TICK     (CPT),
      .MIN_TRIG_CYCLES  (MIN_TRIG),
      .BURST_DELAY_TICKS(BURST_T),
      .MAX_TICKS        (MAX_T),
      .TIMEOUT_TICKS    (TMO_T),
      .HOLDOFF_TICKS    (HOLD_T)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .echo_ticks(echo_ticks),
      .trigger   (trigger),
      .echo      (echo),
      .busy      (busy),
      .ping_done (ping_done),
      .trig_err  (trig_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // One complete ping. mode 0: quiet; mode 1: retrigger in ECHO and HOLDOFF
   // plus an echo_ticks change mid-echo; mode 2: trigger rises in HOLDOFF and
   // is left high.
   task automatic run_ping(input int high, input logic [15:0] ticks, input int mode);
      echo_ticks = ticks;
      trigger = 1'b1;
      repeat (high) step();
      trigger = 1'b0;
      m_rise = 0; m_width = 0; m_hold = 0; m_pd = 0; m_te = 0;
      while (echo !== 1'b1 && m_rise < BOUND) begin
         step();
         m_rise++;
         m_pd += int'(ping_done);
         m_te += int'(trig_err);
      end
      while (echo === 1'b1 && m_width < BOUND) begin
         step();
         m_width++;
         if (mode == 1 && m_width == 5)  trigger = 1'b1;
         if (mode == 1 && m_width == 15) trigger = 1'b0;
         if (mode == 1 && m_width == 20) echo_ticks = 16'd3;
         m_pd += int'(ping_done);
         m_te += int'(trig_err);
      end
      m_pd_at_fall = int'(ping_done);
      while (busy === 1'b1 && m_hold < BOUND) begin
         step();
         m_hold++;
         if (mode != 0 && m_hold == 2)  trigger = 1'b1;
         if (mode == 1 && m_hold == 12) trigger = 1'b0;
         m_pd += int'(ping_done);
         m_te += int'(trig_err);
      end
   endtask

   initial begin
      int first_err, err_cnt, seen;

      // Reset state
      repeat (3) step();
      check("rst_echo", echo, 0);
      check("rst_busy", busy, 0);
      check("rst_ping_done", ping_done, 0);
      check("rst_trig_err", trig_err, 0);
      rst_n = 1'b1;
      enable = 1'b1;
      repeat (2) step();

      // Nominal ping: 10 ticks -> 40 cycles of echo
      run_ping(12, 16'd10, 0);
      check("nom_rise", m_rise, EXP_RISE);
      check("nom_width", m_width, 10 * CPT);
      check("nom_pd_at_fall", m_pd_at_fall, 1);
      check("nom_pd_count", m_pd, 1);
      check("nom_hold", m_hold, EXP_HOLD);
      check("nom_trig_err", m_te, 0);

      // Short trigger: 6 raw cycles -> 5 counted, below MIN_TRIG
      trigger = 1'b1;
      repeat (6) step();
      trigger = 1'b0;
      first_err = -1; err_cnt = 0; seen = 0;
      for (int k = 1; k <= 30; k++) begin
         step();
         if (trig_err === 1'b1) begin
            err_cnt++;
            if (first_err < 0) first_err = k;
         end
         if (echo === 1'b1) seen++;
         if (k == 3) check("short_busy_at_err", busy, 0);
      end
      check("short_err_latency", first_err, 3);
      check("short_err_count", err_cnt, 1);
      check("short_no_echo", seen, 0);

      // Out-of-range and boundary distances
      run_ping(12, 16'd0, 0);
      check("zero_width", m_width, TMO_T * CPT);
      run_ping(12, 16'd5000, 0);
      check("over_width", m_width, TMO_T * CPT);
      run_ping(12, 16'd21, 0);
      check("max_plus1_width", m_width, TMO_T * CPT);
      run_ping(12, 16'd20, 0);
      check("max_width", m_width, MAX_T * CPT);
      run_ping(12, 16'd1, 0);
      check("one_tick_width", m_width, CPT);

      // Retrigger in ECHO/HOLDOFF and echo_ticks change mid-echo
      run_ping(12, 16'd10, 1);
      check("retrig_rise", m_rise, EXP_RISE);
      check("retrig_width", m_width, 10 * CPT);
      check("retrig_hold", m_hold, EXP_HOLD);
      check("retrig_trig_err", m_te, 0);
      check("retrig_pd_count", m_pd, 1);

      // Trigger already high when HOLDOFF ends must not start a ping
      run_ping(12, 16'd6, 2);
      check("stuck_width", m_width, 6 * CPT);
      check("stuck_hold", m_hold, EXP_HOLD);
      seen = 0;
      repeat (20) begin
         step();
         if (busy !== 1'b0) seen++;
      end
      check("stuck_no_accept", seen, 0);
      trigger = 1'b0;
      repeat (4) step();
      run_ping(12, 16'd7, 0);
      check("fresh_edge_width", m_width, 7 * CPT);

      // enable=0 ignores the rising edge
      enable = 1'b0;
      trigger = 1'b1;
      seen = 0;
      repeat (22) begin
         step();
         if (busy !== 1'b0) seen++;
      end
      check("disabled_busy", seen, 0);
      trigger = 1'b0;
      repeat (4) step();
      enable = 1'b1;

      // Asynchronous reset in the middle of an echo
      echo_ticks = 16'd10;
      trigger = 1'b1;
      repeat (12) step();
      trigger = 1'b0;
      seen = 0;
      while (echo !== 1'b1 && seen < BOUND) begin
         step();
         seen++;
      end
      check("pre_reset_rise", seen, EXP_RISE);
      repeat (5) step();
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_echo", echo, 0);
      check("midrst_busy", busy, 0);
      check("midrst_ping_done", ping_done, 0);
      check("midrst_trig_err", trig_err, 0);
      repeat (3) step();
      rst_n = 1'b1;
      repeat (2) step();
      run_ping(12, 16'd9, 0);
      check("post_rst_rise", m_rise, EXP_RISE);
      check("post_rst_width", m_width, 9 * CPT);
      check("post_rst_hold", m_hold, EXP_HOLD);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
